// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one APB master port. PADDR[8]
// selects the slave, and a per-transfer wait-state budget aborts stalled accesses.
module apb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [8:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [8:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic [8:0] PADDR,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

    state_e        state_q;
    logic          last_q;
    logic [CW-1:0] wait_q;
    logic [AW-1:0] paddr_q;
    logic          pwrite_q;
    logic [DW-1:0] pwdata_q;
    logic          psel1_q;
    logic          psel2_q;
    logic          penable_q;
    logic          done0_q;
    logic          done1_q;
    logic          err0_q;
    logic          err1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] gnt_addr;
    logic          gnt_write;
    logic [DW-1:0] gnt_wdata;
    logic          xfer_end;
    logic          end_err;
    logic [DW-1:0] end_rdata;

    // A lone requester wins outright; a tie goes to the one not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE && !PRESET) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign gnt_addr  = gnt1 ? req1_addr  : req0_addr;
    assign gnt_write = gnt1 ? req1_write : req0_write;
    assign gnt_wdata = gnt1 ? req1_wdata : req0_wdata;

    // PREADY wins over the timeout when both land on the same edge.
    assign xfer_end  = (state_q == S_ACCESS) && (PREADY || (wait_q == CW'(TIMEOUT)));
    assign end_err   = PREADY ? PSLVERR : 1'b1;
    assign end_rdata = (PREADY && !pwrite_q) ? PRDATA : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            wait_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        paddr_q  <= gnt_addr;
                        pwrite_q <= gnt_write;
                        pwdata_q <= gnt_wdata;
                        psel1_q  <= ~gnt_addr[AW-1];
                        psel2_q  <= gnt_addr[AW-1];
                        last_q   <= gnt1;
                        wait_q   <= '0;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (xfer_end) begin
                        // last_q still names the owner of the running transfer.
                        if (last_q) begin
                            done1_q  <= 1'b1;
                            err1_q   <= end_err;
                            rdata1_q <= end_rdata;
                        end else begin
                            done0_q  <= 1'b1;
                            err0_q   <= end_err;
                            rdata0_q <= end_rdata;
                        end
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;
    assign PSEL1      = psel1_q;
    assign PSEL2      = psel2_q;
    assign PENABLE    = penable_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios plus a randomized run against a
// transaction-timeline reference model of the arbiter and an APB slave.
`timescale 1ns/1ps
module tb_apb_rr_arbiter;
    localparam int TO = 15;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [8:0] req0_addr;
    logic [7:0] req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [8:0] req1_addr;
    logic [7:0] req1_wdata, req1_rdata;
    logic       PSEL1, PSEL2, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [8:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    apb_rr_arbiter #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic apply_reset();
        PRESET = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_bus: got %b want 0000", {PSEL1, PSEL2, PENABLE, PWRITE});
        end
        n_checks++;
        if ({req0_ready, req1_ready, req0_done, req1_done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 0000", {req0_ready, req1_ready, req0_done, req1_done});
        end
        n_checks++;
        if ({PADDR, PWDATA, req0_rdata, req0_err, req1_rdata, req1_err} !== 35'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {PADDR, PWDATA, req0_rdata, req0_err, req1_rdata, req1_err});
        end
        tick();
        PRESET = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_tie: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_ready: got %b want 00", {req0_ready, req1_ready});
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        PRDATA = 8'hA5;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h005;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req0_addr = 9'h1FF;
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE, PADDR, req0_done} !== {3'b100, 9'h005, 1'b0}) begin
            n_fail++; $display("FAIL single_setup: got %b/%h/%b want 100/005/0", {PSEL1, PSEL2, PENABLE}, PADDR, req0_done);
        end
        tick();
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE, PADDR} !== {3'b101, 9'h005}) begin
            n_fail++; $display("FAIL single_access: got %b/%h want 101/005", {PSEL1, PSEL2, PENABLE}, PADDR);
        end
        tick();
        n_checks++;
        if ({req0_done, req1_done, req0_rdata, req0_err, PSEL1, PSEL2, PENABLE} !== {2'b10, 8'hA5, 4'b0000}) begin
            n_fail++; $display("FAIL single_done: got done=%b rdata=%h err=%b want 10/a5/0", {req0_done, req1_done}, req0_rdata, req0_err);
        end
        tick();
        n_checks++;
        if ({req0_done, req0_rdata} !== {1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL single_hold: got done=%b rdata=%h want 0/a5", req0_done, req0_rdata);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        PRDATA = 8'h77;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h101; req0_wdata = 8'h3C;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h002;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL cont_tie1: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE, PWRITE, PWDATA, PADDR, req1_ready} !== {4'b0101, 8'h3C, 9'h101, 1'b0}) begin
            n_fail++; $display("FAIL cont_req0_setup: got %b/%h/%h rdy1=%b want 0101/3c/101/0",
                               {PSEL1, PSEL2, PENABLE, PWRITE}, PWDATA, PADDR, req1_ready);
        end
        tick();
        tick();
        n_checks++;
        if ({req0_done, req1_done, req0_rdata, req0_err, req1_ready} !== {2'b10, 8'h00, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL cont_req0_done: got done=%b rdata=%h err=%b rdy1=%b want 10/00/0/1",
                               {req0_done, req1_done}, req0_rdata, req0_err, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_checks++;
        if ({PSEL1, PSEL2, PWRITE, PADDR} !== {3'b100, 9'h002}) begin
            n_fail++; $display("FAIL cont_req1_setup: got %b/%h want 100/002", {PSEL1, PSEL2, PWRITE}, PADDR);
        end
        tick();
        tick();
        n_checks++;
        if ({req0_done, req1_done, req1_rdata, req1_err} !== {2'b01, 8'h77, 1'b0}) begin
            n_fail++; $display("FAIL cont_req1_done: got done=%b rdata=%h err=%b want 01/77/0",
                               {req0_done, req1_done}, req1_rdata, req1_err);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL cont_tie3: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_wait_states();
        apply_reset();
        PREADY = 1'b0; PRDATA = 8'h5A;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h0AA;
        tick();
        req1_valid = 1'b0; req1_addr = 9'h000;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({PSEL1, PENABLE, PADDR, req1_done} !== {2'b11, 9'h0AA, 1'b0}) begin
                n_fail++; $display("FAIL wait_access%0d: got %b/%h done=%b want 11/0aa/0", i, {PSEL1, PENABLE}, PADDR, req1_done);
            end
            if (i == 4) PREADY = 1'b1;
            tick();
        end
        n_checks++;
        if ({req1_done, req1_rdata, PENABLE} !== {1'b1, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL wait_done: got done=%b rdata=%h pen=%b want 1/5a/0", req1_done, req1_rdata, PENABLE);
        end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        PREADY = 1'b0; PRDATA = 8'hFF;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h123;
        tick();
        req0_valid = 1'b0;
        tick();
        n = 0;
        while (req0_done !== 1'b1 && n < 40) begin
            if (PENABLE === 1'b1) n++;
            tick();
        end
        n_checks++;
        if ({req0_done, req0_rdata, req0_err} !== {1'b1, 8'h00, 1'b1} || n != TO + 1) begin
            n_fail++; $display("FAIL timeout_abort: got done=%b rdata=%h err=%b access=%0d want 1/00/1/%0d",
                               req0_done, req0_rdata, req0_err, n, TO + 1);
        end
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_bus_idle: got %b want 000", {PSEL1, PSEL2, PENABLE});
        end
        // PREADY arriving on the very edge the budget runs out still completes normally.
        PRDATA = 8'h3D;
        req0_valid = 1'b1; req0_addr = 9'h0F0;
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (req0_done !== 1'b0) begin
            n_fail++; $display("FAIL timeout_single_pulse: got %b want 0", req0_done);
        end
        tick();
        for (int i = 0; i < TO; i++) tick();
        PREADY = 1'b1;
        tick();
        n_checks++;
        if ({req0_done, req0_rdata, req0_err} !== {1'b1, 8'h3D, 1'b0}) begin
            n_fail++; $display("FAIL timeout_boundary: got done=%b rdata=%h err=%b want 1/3d/0", req0_done, req0_rdata, req0_err);
        end
    endtask

    task automatic test_slave_error();
        apply_reset();
        PSLVERR = 1'b1; PRDATA = 8'hEE;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h1C0; req1_wdata = 8'h99;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req1_done, req1_err, req1_rdata, req0_done, req0_err} !== {2'b11, 8'h00, 2'b00}) begin
            n_fail++; $display("FAIL slverr_write: got done=%b err=%b rdata=%h r0=%b%b want 1/1/00/00",
                               req1_done, req1_err, req1_rdata, req0_done, req0_err);
        end
        PSLVERR = 1'b0; PRDATA = 8'h42;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h010;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req1_done, req1_err, req1_rdata} !== {2'b10, 8'h42}) begin
            n_fail++; $display("FAIL slverr_next_ok: got done=%b err=%b rdata=%h want 1/0/42", req1_done, req1_err, req1_rdata);
        end
    endtask

    task automatic test_reset_in_access();
        apply_reset();
        PRDATA = 8'h11;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h033;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        PREADY = 1'b0;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if ({PSEL1, PSEL2, PENABLE, req0_done, req0_rdata} !== {4'b0000, 8'h00}) begin
            n_fail++; $display("FAIL rst_access_async: got %b rdata=%h want 0000/00", {PSEL1, PSEL2, PENABLE, req0_done}, req0_rdata);
        end
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({req0_done, req1_done, PSEL1, PENABLE} !== 4'b0000) begin
                n_fail++; $display("FAIL rst_access_no_done%0d: got %b want 0000", i, {req0_done, req1_done, PSEL1, PENABLE});
            end
            tick();
        end
        PRDATA = 8'h66;
        req0_valid = 1'b1; req0_addr = 9'h077;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req0_done, req0_rdata, req0_err} !== {1'b1, 8'h66, 1'b0}) begin
            n_fail++; $display("FAIL rst_access_recover: got done=%b rdata=%h err=%b want 1/66/0", req0_done, req0_rdata, req0_err);
        end
    endtask

    // Reference model: each accepted command occupies the bus for a fixed timeline
    // (1 setup cycle, 1+min(waits,TO) access cycles) and completes one cycle later.
    task automatic test_random();
        bit         pv[2];
        bit         pw[2];
        logic [8:0] pa[2];
        logic [7:0] pd[2];
        logic [7:0] e_rd[2];
        bit         e_err[2];
        bit         act, a_wr, a_err, m_last, in_setup, in_access, x_d0, x_d1, want0, want1;
        int         a_req, a_acc, a_w, a_eff, k, sel;
        logic [8:0] a_addr;
        logic [7:0] a_wd, a_rd;
        apply_reset();
        m_last = 1'b1; act = 1'b0; a_acc = 0; a_w = 0; a_eff = 0; a_req = 0;
        a_wr = 1'b0; a_err = 1'b0; a_addr = '0; a_wd = '0; a_rd = '0;
        for (int r = 0; r < 2; r++) begin
            pv[r] = 1'b0; pw[r] = 1'b0; pa[r] = '0; pd[r] = '0; e_rd[r] = '0; e_err[r] = 1'b0;
        end
        for (int c = 0; c < 1500; c++) begin
            k = c - a_acc;
            in_setup  = act && (k == 1);
            in_access = act && (k >= 2) && (k <= 2 + a_eff);
            x_d0 = act && (k == 3 + a_eff) && (a_req == 0);
            x_d1 = act && (k == 3 + a_eff) && (a_req == 1);
            if (act && k == 3 + a_eff) begin
                e_rd[a_req]  = a_rd;
                e_err[a_req] = a_err;
                act = 1'b0;
            end
            n_checks++;
            if ({req0_done, req1_done} !== {x_d0, x_d1}) begin
                n_fail++; $display("FAIL rand_done c=%0d: got %b want %b", c, {req0_done, req1_done}, {x_d0, x_d1});
            end
            n_checks++;
            if ({PSEL1, PSEL2, PENABLE} !== {(in_setup || in_access) && !a_addr[8], (in_setup || in_access) && a_addr[8], in_access}) begin
                n_fail++; $display("FAIL rand_bus c=%0d: got %b want %b", c, {PSEL1, PSEL2, PENABLE},
                                   {(in_setup || in_access) && !a_addr[8], (in_setup || in_access) && a_addr[8], in_access});
            end
            if (in_setup || in_access) begin
                n_checks++;
                if ({PADDR, PWRITE, PWDATA} !== {a_addr, a_wr, a_wd}) begin
                    n_fail++; $display("FAIL rand_cmd c=%0d: got %h/%b/%h want %h/%b/%h", c, PADDR, PWRITE, PWDATA, a_addr, a_wr, a_wd);
                end
            end
            n_checks++;
            if ({req0_rdata, req0_err, req1_rdata, req1_err} !== {e_rd[0], e_err[0], e_rd[1], e_err[1]}) begin
                n_fail++; $display("FAIL rand_resp c=%0d: got %h/%b %h/%b want %h/%b %h/%b", c, req0_rdata, req0_err,
                                   req1_rdata, req1_err, e_rd[0], e_err[0], e_rd[1], e_err[1]);
            end
            // Slave: raise PREADY after the planned number of wait cycles.
            PRDATA  = 8'($urandom);
            PSLVERR = 1'($urandom);
            PREADY  = in_access ? (k - 2 == a_w) : 1'($urandom);
            if (in_access && (k - 2 == a_eff)) begin
                a_err = (a_w > TO) ? 1'b1 : PSLVERR;
                a_rd  = (a_w > TO || a_wr) ? 8'h00 : PRDATA;
            end
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 2) == 0) begin
                    pv[r] = 1'b1; pw[r] = 1'($urandom); pa[r] = 9'($urandom); pd[r] = 8'($urandom);
                end
            end
            req0_valid = pv[0] && ($urandom_range(0, 4) != 0);
            req0_write = pv[0] ? pw[0] : 1'($urandom);
            req0_addr  = pv[0] ? pa[0] : 9'($urandom);
            req0_wdata = pv[0] ? pd[0] : 8'($urandom);
            req1_valid = pv[1] && ($urandom_range(0, 4) != 0);
            req1_write = pv[1] ? pw[1] : 1'($urandom);
            req1_addr  = pv[1] ? pa[1] : 9'($urandom);
            req1_wdata = pv[1] ? pd[1] : 8'($urandom);
            want0 = 1'b0;
            want1 = 1'b0;
            if (!act && (req0_valid || req1_valid)) begin
                sel = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req1_valid ? 1 : 0);
                want0 = (sel == 0);
                want1 = (sel == 1);
            end
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {want0, want1}) begin
                n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, {req0_ready, req1_ready}, {want0, want1});
            end
            if (want0 || want1) begin
                a_req  = want1 ? 1 : 0;
                act    = 1'b1;
                a_acc  = c;
                a_wr   = pw[a_req];
                a_addr = pa[a_req];
                a_wd   = pd[a_req];
                pv[a_req] = 1'b0;
                m_last = (a_req == 1);
                sel = $urandom_range(0, 7);
                case (sel)
                    0, 1, 2, 3: a_w = sel;
                    4:          a_w = TO;
                    5:          a_w = TO - 1;
                    6:          a_w = TO + 1 + $urandom_range(0, 3);
                    default:    a_w = 1;
                endcase
                a_eff = (a_w > TO) ? TO : a_w;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_slave_error();
        test_reset_in_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
